// File: rtl/dma_desc_dispatch_if.sv
// Descriptor dispatch bus: FIFO pop side, read/write command
// channels and completion pulses, seen from the dispatcher.
interface dma_desc_dispatch_if #(
  parameter int LEN_W = 16
) ();
  logic             dma_desc_fifo_empty_i;
  logic             dma_desc_fifo_rd_o;
  logic [255:0]     dma_desc_fifo_rddata_i;
  logic             dma_rd_cmd_valid_o;
  logic             dma_rd_cmd_ready_i;
  logic [31:0]      dma_rd_cmd_addr_o;
  logic [LEN_W-1:0] dma_rd_cmd_len_o;
  logic             dma_rd_done_i;
  logic             dma_wr_cmd_valid_o;
  logic             dma_wr_cmd_ready_i;
  logic [31:0]      dma_wr_cmd_addr_o;
  logic [LEN_W-1:0] dma_wr_cmd_len_o;
  logic             dma_wr_done_i;
  logic             dma_desc_done_o;
  logic             dma_irq_o;

  modport master (
    input  dma_desc_fifo_empty_i,
    output dma_desc_fifo_rd_o,
    input  dma_desc_fifo_rddata_i,
    output dma_rd_cmd_valid_o,
    input  dma_rd_cmd_ready_i,
    output dma_rd_cmd_addr_o,
    output dma_rd_cmd_len_o,
    input  dma_rd_done_i,
    output dma_wr_cmd_valid_o,
    input  dma_wr_cmd_ready_i,
    output dma_wr_cmd_addr_o,
    output dma_wr_cmd_len_o,
    input  dma_wr_done_i,
    output dma_desc_done_o,
    output dma_irq_o
  );

  modport slave (
    output dma_desc_fifo_empty_i,
    input  dma_desc_fifo_rd_o,
    output dma_desc_fifo_rddata_i,
    input  dma_rd_cmd_valid_o,
    output dma_rd_cmd_ready_i,
    input  dma_rd_cmd_addr_o,
    input  dma_rd_cmd_len_o,
    output dma_rd_done_i,
    input  dma_wr_cmd_valid_o,
    output dma_wr_cmd_ready_i,
    input  dma_wr_cmd_addr_o,
    input  dma_wr_cmd_len_o,
    output dma_wr_done_i,
    input  dma_desc_done_o,
    input  dma_irq_o
  );
endinterface

// File: rtl/dma_desc_dispatch.sv
// Pops 256-bit descriptors, issues read/write commands, waits for
// both completions, then pulses done/irq and bumps the count.
module dma_desc_dispatch #(
  parameter int LEN_W = 16,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         csr_control_i,
  dma_desc_dispatch_if.master bus,
  output logic                csr_busy_o,
  output logic [CNT_W-1:0]    csr_desc_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LATCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_len;
  logic             r_irq_en;
  logic             r_rd_acc;
  logic             r_wr_acc;
  logic             r_rd_dn;
  logic             r_wr_dn;
  logic [CNT_W-1:0] r_count;

  logic             w_run;
  logic [31:0]      w_src;
  logic [31:0]      w_dst;
  logic [LEN_W-1:0] w_len;
  logic             w_own;
  logic             w_irq;
  logic             w_rd_vld;
  logic             w_wr_vld;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_live;
  logic             w_unused;

  assign w_run = csr_control_i[5];
  assign w_src = bus.dma_desc_fifo_rddata_i[31:0];
  assign w_dst = bus.dma_desc_fifo_rddata_i[95:64];
  assign w_len = bus.dma_desc_fifo_rddata_i[192 +: LEN_W];
  assign w_own = bus.dma_desc_fifo_rddata_i[231];
  assign w_irq = bus.dma_desc_fifo_rddata_i[232];

  assign w_unused = ^{csr_control_i, bus.dma_desc_fifo_rddata_i};

  assign w_rd_vld = (r_state == S_ISSUE) && !r_rd_acc;
  assign w_wr_vld = (r_state == S_ISSUE) && !r_wr_acc;
  assign w_rd_acc = r_rd_acc || (w_rd_vld && bus.dma_rd_cmd_ready_i);
  assign w_wr_acc = r_wr_acc || (w_wr_vld && bus.dma_wr_cmd_ready_i);
  assign w_live   = (r_state == S_ISSUE) || (r_state == S_WAIT);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_run && !bus.dma_desc_fifo_empty_i) w_next = S_POP;
      end
      S_POP:   w_next = S_LATCH;
      S_LATCH: begin
        if (!w_own)             w_next = S_IDLE;
        else if (w_len == '0)   w_next = S_DONE;
        else                    w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_rd_acc && w_wr_acc) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (r_rd_dn && r_wr_dn) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_src    <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_irq_en <= 1'b0;
      r_rd_acc <= 1'b0;
      r_wr_acc <= 1'b0;
      r_rd_dn  <= 1'b0;
      r_wr_dn  <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_LATCH) begin
        r_src    <= w_src;
        r_dst    <= w_dst;
        r_len    <= w_len;
        r_irq_en <= w_irq;
      end
      // done pulses only count once the command phase has begun
      if (r_state == S_LATCH || r_state == S_DONE) begin
        r_rd_acc <= 1'b0;
        r_wr_acc <= 1'b0;
        r_rd_dn  <= 1'b0;
        r_wr_dn  <= 1'b0;
      end else if (w_live) begin
        r_rd_acc <= w_rd_acc;
        r_wr_acc <= w_wr_acc;
        r_rd_dn  <= r_rd_dn || bus.dma_rd_done_i;
        r_wr_dn  <= r_wr_dn || bus.dma_wr_done_i;
      end
      if (r_state == S_DONE) r_count <= r_count + 1'b1;
    end
  end

  assign bus.dma_desc_fifo_rd_o = (r_state == S_POP);
  assign bus.dma_rd_cmd_valid_o = w_rd_vld;
  assign bus.dma_rd_cmd_addr_o  = r_src;
  assign bus.dma_rd_cmd_len_o   = r_len;
  assign bus.dma_wr_cmd_valid_o = w_wr_vld;
  assign bus.dma_wr_cmd_addr_o  = r_dst;
  assign bus.dma_wr_cmd_len_o   = r_len;
  assign bus.dma_desc_done_o    = (r_state == S_DONE);
  assign bus.dma_irq_o          = (r_state == S_DONE) && r_irq_en;
  assign csr_busy_o             = (r_state != S_IDLE);
  assign csr_desc_count_o       = r_count;

endmodule

// File: doc/dma_desc_dispatch.md
Name: dma_desc_dispatch

Overview:
Downstream consumer of the descriptor FIFO that dma_desc_fetch fills. It pops one 256-bit descriptor at a time and decodes the source address, destination address, length and control fields. It issues a read command to the DMA read master and a write command to the DMA write master, waits for both to report completion, then signals descriptor done, an optional interrupt, and a completed-descriptor count to the CSR block. Descriptors whose owned_by_hw bit is clear are chain terminators: the block pops and discards them without issuing any transfer.

Parameters:
LEN_W  16  width of the byte-length field and of the command length outputs
CNT_W  16  width of the completed-descriptor counter

Ports:
clk  input  1  clock; all logic on its rising edge
reset  input  1  synchronous, active-low reset; low on a rising clk edge resets the block
csr_control_i  input  32  CSR control register; bit 5 = run
dma_desc_fifo_empty_i  input  1  descriptor FIFO empty
dma_desc_fifo_rd_o  output  1  FIFO read strobe, one-cycle pulse
dma_desc_fifo_rddata_i  input  256  FIFO read data, valid the cycle after rd
dma_rd_cmd_valid_o  output  1  read-master command valid
dma_rd_cmd_ready_i  input  1  read-master command accepted
dma_rd_cmd_addr_o  output  32  source address
dma_rd_cmd_len_o  output  LEN_W  byte count
dma_rd_done_i  input  1  read master finished, one-cycle pulse
dma_wr_cmd_valid_o  output  1  write-master command valid
dma_wr_cmd_ready_i  input  1  write-master command accepted
dma_wr_cmd_addr_o  output  32  destination address
dma_wr_cmd_len_o  output  LEN_W  byte count
dma_wr_done_i  input  1  write master finished, one-cycle pulse
dma_desc_done_o  output  1  one-cycle pulse per completed descriptor
dma_irq_o  output  1  one-cycle pulse, only when the descriptor's irq_en bit is set
csr_busy_o  output  1  high whenever the state is not IDLE
csr_desc_count_o  output  CNT_W  count of completed descriptors

Behaviour:
- Descriptor layout, where word n = rddata[32n+31:32n]:
  - w0 = source address
  - w2 = destination address
  - w4 = next pointer (ignored by this block)
  - w6[LEN_W-1:0] = length in bytes
  - w7[7] = owned_by_hw
  - w7[8] = irq_en
  - w1, w3, w5 and all other bits are ignored.
- Reset (reset low on a clock edge):
  - state goes to IDLE
  - every output goes to 0, including csr_desc_count_o
  - descriptor registers, the accept flags and the done flags clear
  - reset mid-transfer abandons the descriptor; no done pulse is produced.
- IDLE: if run and ~empty, go to POP; otherwise stay in IDLE.
- POP: dma_desc_fifo_rd_o = 1 for exactly this cycle; next state is LATCH.
- LATCH: rddata_i is valid this cycle.
  - Capture src, dst, len and irq_en into registers.
  - If owned_by_hw = 0, go to IDLE (discard; no pulses, count unchanged).
  - Else if len = 0, go to COMPLETE (no commands issued).
  - Else go to ISSUE.
- ISSUE:
  - rd_cmd_valid and wr_cmd_valid are driven high from the registered fields.
  - Each valid stays high until its ready is sampled high; it drops in the cycle after acceptance.
  - The addr and len outputs stay stable while the corresponding valid is high.
  - The two channels are accepted independently and in any order.
  - When both have been accepted, go to WAIT_DONE.
- Done capture: rd_done and wr_done pulses are captured into sticky flags from entry to ISSUE onward. A done pulse may arrive in the same cycle as its own accept, or before the other channel is accepted.
- WAIT_DONE: when both sticky flags are set, go to COMPLETE. Done pulses seen outside ISSUE/WAIT_DONE are ignored.
- COMPLETE (one cycle):
  - dma_desc_done_o = 1
  - dma_irq_o = irq_en
  - csr_desc_count_o increments; it wraps from 2^CNT_W-1 to 0
  - flags clear; next state is IDLE.
- Latency:
  - Non-empty FIFO in IDLE to cmd valids high = 3 cycles (IDLE, POP, LATCH, then ISSUE).
  - With ready tied high and done returned the cycle after accept, IDLE to done pulse = 6 cycles.
- Run deasserted mid-descriptor: the current descriptor completes normally, and no further pop occurs while run = 0.
- Empty FIFO while run = 1: the block stays in IDLE with rd_o = 0. It never pops when empty.
- Back-to-back descriptors: IDLE is visited for at least one cycle between descriptors, so at most one descriptor is in flight.
- Only 0/1 outputs are driven while ISSUE is inactive: cmd valids = 0, pulses = 0; addr/len hold their last values.

Test Plan:
- Reset: hold reset low 2 cycles with the FIFO non-empty -> all outputs 0, no rd pulse; release -> rd pulse in the 2nd cycle after release, given run = 1.
- Single descriptor: w0=0x1000, w2=0x2000, w6=0x40, w7=0x180, readies high, done 1 cycle after accept -> rd addr 0x1000 len 0x40, wr addr 0x2000 len 0x40; one done pulse, one irq pulse, count = 1.
- Skewed handshake: rd_ready delayed 5 cycles, wr_done arrives before rd accept, rd_done 10 cycles later -> valids held stable until accepted; exactly one done pulse after rd_done; irq = 0 when w7=0x080.
- Terminator: FIFO holds one descriptor with w7=0x000 -> one rd pulse; no cmd valids, no done pulse, count unchanged, busy high for 2 cycles.
- Zero length: w6=0, w7=0x080 -> no cmd valids; done pulse in the cycle after LATCH; count increments.
- Run/reset mid-op: clear run during WAIT_DONE with 3 descriptors queued -> the current one completes and no further pops occur. Separately, assert reset during WAIT_DONE -> no done pulse, count = 0, state IDLE.
